versatile_fifo_ram_reader: RTL and testbench



---
 rtl/versatile_fifo_pkg.sv | 25 ++
 rtl/versatile_fifo_skid_buf.sv | 92 +++++++++
 rtl/versatile_fifo_ram_reader.sv | 122 ++++++++++++
 tb/tb_versatile_fifo_ram_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/versatile_fifo_pkg.sv
// ---------------------------------------------------------------------------
// versatile_fifo_pkg
// Shared definitions for the versatile FIFO read and write controllers.
//   DEF_ADDR_WIDTH : default RAM address width
//   ptr_width()    : pointer width (address width plus one wrap bit)
//   ptr_t          : pointer type for the default configuration
//   bin2gray()     : binary to Gray conversion (low bits used by callers)
// ---------------------------------------------------------------------------
package versatile_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 11;

    // Pointers carry one extra bit so full and empty can be told apart.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    // Works for any pointer up to 32 bits; the caller truncates to its width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/versatile_fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// versatile_fifo_skid_buf
// Two-entry valid/ready buffer with push, pop and flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the buffer; wins over push and pop
//   push        : write push_data at the tail
//   pop         : consume the head (ignored when empty)
//   head        : registered head entry
//   head_valid  : registered, high when the buffer holds a word
//   count       : number of stored entries (0..2)
// Push into a full buffer without a pop is not supported; the caller's
// issue logic guarantees it never happens.
// ---------------------------------------------------------------------------
module versatile_fifo_skid_buf
    import versatile_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] tail_reg, tail_next;
    logic [1:0]       cnt_reg,  cnt_next;
    logic             valid_reg;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        cnt_next  = cnt_reg;
        if (flush) begin
            cnt_next = 2'd0;
        end else begin
            case (cnt_reg)
                2'd0: begin
                    if (push) begin
                        head_next = push_data;
                        cnt_next  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // New word goes straight to the head as the old one leaves.
                        head_next = push_data;
                    end else if (push) begin
                        tail_next = push_data;
                        cnt_next  = 2'd2;
                    end else if (pop) begin
                        cnt_next = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_next = tail_reg;
                        if (push) begin
                            tail_next = push_data;
                        end else begin
                            cnt_next = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            cnt_reg   <= 2'd0;
            valid_reg <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            cnt_reg   <= cnt_next;
            valid_reg <= (cnt_next != 2'd0);
        end
    end

    assign head       = head_reg;
    assign head_valid = valid_reg;
    assign count      = cnt_reg;

endmodule

// File: rtl/versatile_fifo_ram_reader.sv
// ---------------------------------------------------------------------------
// versatile_fifo_ram_reader
// Read-side controller for the FIFO dual-port RAM (port B). Issues reads
// while the RAM holds unread words and buffer space is available, and
// presents the words as a valid/ready stream at one word per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_ptr      : binary write pointer, already synchronised to clk
//   clr         : synchronous flush (rd_ptr <= wr_ptr, buffer emptied)
//   adr_b       : RAM port B address
//   rd_en_b     : RAM port B read strobe
//   q_b         : RAM port B data, valid the cycle after rd_en_b
//   dout        : stream data (head of the output buffer)
//   dout_valid  : dout holds a word
//   dout_ready  : consumer accepts the word
//   rd_ptr      : binary read pointer (count of issued reads)
//   rd_ptr_gray : Gray-coded read pointer, only with VERSATILE_FIFO_RD_GRAY_EN
// ---------------------------------------------------------------------------
module versatile_fifo_ram_reader
    import versatile_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] adr_b,
    output logic                  rd_en_b,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   rd_ptr
`ifdef VERSATILE_FIFO_RD_GRAY_EN
    ,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray
`endif
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             inflight_reg;
    logic [1:0]       buf_cnt;
    logic [1:0]       slots;
    logic             ram_empty;
    logic             pop;
    logic             issue;

    assign ram_empty = (rd_ptr_reg == wr_ptr);
    assign pop       = dout_valid & dout_ready;
    assign slots     = buf_cnt + {1'b0, inflight_reg};

    // A read may be issued into the slot that a pop frees this same cycle,
    // which is what sustains one word per clock. rst_n gating keeps the
    // strobe quiet while reset is held, even if wr_ptr has not cleared yet.
    assign issue = rst_n & !ram_empty & !clr &
                   ((slots < 2'd2) | ((slots == 2'd2) & pop));

    assign rd_en_b = issue;
    assign adr_b   = rd_ptr_reg[ADDR_WIDTH-1:0];

    assign rd_ptr_next = clr ? wr_ptr : (rd_ptr_reg + PTR_W'(issue));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            inflight_reg <= issue;
        end
    end

    assign rd_ptr = rd_ptr_reg;

    // Flush has priority inside the buffer, so a word still in flight when
    // clr is seen is dropped rather than captured.
    versatile_fifo_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (clr),
        .push       (inflight_reg),
        .push_data  (q_b),
        .pop        (pop),
        .head       (dout),
        .head_valid (dout_valid),
        .count      (buf_cnt)
    );

`ifdef VERSATILE_FIFO_RD_GRAY_EN
    logic [PTR_W-1:0] rd_ptr_gray_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_gray_reg <= '0;
        end else begin
            rd_ptr_gray_reg <= PTR_W'(bin2gray(32'(rd_ptr_next)));
        end
    end

    assign rd_ptr_gray = rd_ptr_gray_reg;
`endif

`ifndef SYNTHESIS
    // The writer may never lead by more than the RAM depth. A clr cycle is
    // exempt: it realigns rd_ptr to wr_ptr wherever the writer is.
    localparam logic [PTR_W-1:0] PTR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};
    logic [PTR_W-1:0] fill_level;
    assign fill_level = wr_ptr - rd_ptr_reg;

    always @(posedge clk) begin
        if (rst_n && !clr) begin
            assert (fill_level <= PTR_SPAN);
        end
    end
`endif

endmodule

// File: tb/tb_versatile_fifo_ram_reader.sv
module tb_versatile_fifo_ram_reader;
    import versatile_fifo_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] wr_ptr = '0;
    logic          clr = 1'b0;
    logic [AW-1:0] adr_b;
    logic          rd_en_b;
    logic [DW-1:0] q_b = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [PW-1:0] rd_ptr;
`ifdef VERSATILE_FIFO_RD_GRAY_EN
    logic [PW-1:0] rd_ptr_gray;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // RAM port B model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (rd_en_b) q_b <= ram[adr_b];
    end

    versatile_fifo_ram_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr      (wr_ptr),
        .clr         (clr),
        .adr_b       (adr_b),
        .rd_en_b     (rd_en_b),
        .q_b         (q_b),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .rd_ptr      (rd_ptr)
`ifdef VERSATILE_FIFO_RD_GRAY_EN
        ,
        .rd_ptr_gray (rd_ptr_gray)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_ptr = '0; clr = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_ptr = '0; clr = 1'b0; dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd_en_b !== 1'b0 || dout_valid !== 1'b0 || rd_ptr !== 5'd0 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_values: rd_en_b=%b dout_valid=%b rd_ptr=%0d dout=%h expected 0 0 0 00",
                     rd_en_b, dout_valid, rd_ptr, dout);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd_en_b !== 1'b0 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: rd_en_b=%b dout_valid=%b expected 0 0", rd_en_b, dout_valid);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        wr_ptr = 5'd1;
        #1;
        tests_run++;
        if (rd_en_b !== 1'b1 || adr_b !== 4'd0) begin
            tests_failed++;
            $display("FAIL single_issue: rd_en_b=%b adr_b=%0d expected 1 0", rd_en_b, adr_b);
        end
        @(negedge clk);
        tests_run++;
        if (rd_en_b !== 1'b0 || rd_ptr !== 5'd1 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_cycle1: rd_en_b=%b rd_ptr=%0d dout_valid=%b expected 0 1 0",
                     rd_en_b, rd_ptr, dout_valid);
        end
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_data: dout_valid=%b dout=%h expected 1 a5", dout_valid, dout);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pop: dout_valid=%b expected 0", dout_valid);
        end
        dout_ready = 1'b0;
        $display("[TB] test_single done");
    endtask

    task automatic test_burst();
        int k = 0;
        int first = -1;
        int last = -1;
        do_reset();
        dout_ready = 1'b1;
        wr_ptr = 5'd16;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                if (first < 0) first = c;
                last = c;
                tests_run++;
                if (k > 15 || dout !== ram[k % 16]) begin
                    tests_failed++;
                    $display("FAIL burst_data[%0d]: dout=%h expected %h", k, dout, ram[k % 16]);
                end
                k++;
            end
        end
        tests_run++;
        if (k !== 16 || first !== 2 || (last - first + 1) !== 16) begin
            tests_failed++;
            $display("FAIL burst_timing: beats=%0d first=%0d span=%0d expected 16 2 16",
                     k, first, last - first + 1);
        end
        tests_run++;
        if (rd_ptr !== 5'd16 || adr_b !== 4'd0 || rd_en_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_end: rd_ptr=%0d adr_b=%0d rd_en_b=%b expected 16 0 0",
                     rd_ptr, adr_b, rd_en_b);
        end
        $display("[TB] test_burst done");
    endtask

    task automatic test_backpressure();
        int issues = 0;
        int unstable = 0;
        int k = 0;
        do_reset();
        wr_ptr = 5'd8;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rd_en_b) issues++;
            if (dout_valid && dout !== ram[0]) unstable++;
            @(negedge clk);
        end
        tests_run++;
        if (issues !== 2 || rd_ptr !== 5'd2) begin
            tests_failed++;
            $display("FAIL bp_issues: issued=%0d rd_ptr=%0d expected 2 2", issues, rd_ptr);
        end
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== ram[0] || unstable !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: dout_valid=%b dout=%h unstable=%0d expected 1 %h 0",
                     dout_valid, dout, unstable, ram[0]);
        end
        dout_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (dout_valid) begin
                tests_run++;
                if (k > 7 || dout !== ram[k % 16]) begin
                    tests_failed++;
                    $display("FAIL bp_data[%0d]: dout=%h expected %h", k, dout, ram[k % 16]);
                end
                k++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (k !== 8 || rd_ptr !== 5'd8) begin
            tests_failed++;
            $display("FAIL bp_total: delivered=%0d rd_ptr=%0d expected 8 8", k, rd_ptr);
        end
        dout_ready = 1'b0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_adr [4];
        logic [AW-1:0] got_adr [4];
        logic [DW-1:0] got_dat [4];
        int n_iss = 0;
        int n_dat = 0;
        int empty_bad = 0;
        exp_adr[0] = 4'd14; exp_adr[1] = 4'd15; exp_adr[2] = 4'd0; exp_adr[3] = 4'd1;
        do_reset();
        wr_ptr = 5'd30;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests_run++;
        if (rd_ptr !== 5'd30 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_load: rd_ptr=%0d dout_valid=%b expected 30 0", rd_ptr, dout_valid);
        end
        wr_ptr = 5'd2;
        dout_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            // Reader is never slot-limited here, so it issues exactly when the RAM is not empty.
            if (rd_en_b !== (rd_ptr != 5'd2)) empty_bad++;
            if (rd_en_b) begin
                if (n_iss < 4) got_adr[n_iss] = adr_b;
                n_iss++;
            end
            if (dout_valid) begin
                if (n_dat < 4) got_dat[n_dat] = dout;
                n_dat++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (n_iss !== 4 || n_dat !== 4 || empty_bad !== 0 || rd_ptr !== 5'd2) begin
            tests_failed++;
            $display("FAIL wrap_counts: issues=%0d words=%0d empty_bad=%0d rd_ptr=%0d expected 4 4 0 2",
                     n_iss, n_dat, empty_bad, rd_ptr);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= n_iss || got_adr[i] !== exp_adr[i] || i >= n_dat || got_dat[i] !== ram[exp_adr[i]]) begin
                tests_failed++;
                $display("FAIL wrap_beat[%0d]: adr=%0d data=%h expected %0d %h",
                         i, got_adr[i], got_dat[i], exp_adr[i], ram[exp_adr[i]]);
            end
        end
        dout_ready = 1'b0;
        $display("[TB] test_wrap done");
    endtask

    task automatic test_clr();
        do_reset();
        wr_ptr = 5'd1;
        @(negedge clk);
        @(negedge clk);
        wr_ptr = 5'd2;
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== ram[0]) begin
            tests_failed++;
            $display("FAIL clr_setup: dout_valid=%b dout=%h expected 1 %h", dout_valid, dout, ram[0]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests_run++;
        if (dout_valid !== 1'b0 || rd_ptr !== 5'd2 || rd_en_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_flush: dout_valid=%b rd_ptr=%0d rd_en_b=%b expected 0 2 0",
                     dout_valid, rd_ptr, rd_en_b);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_drop_inflight: dout_valid=%b expected 0", dout_valid);
        end
        wr_ptr = 5'd3;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== ram[2] || rd_ptr !== 5'd3) begin
            tests_failed++;
            $display("FAIL clr_next_word: dout_valid=%b dout=%h rd_ptr=%0d expected 1 %h 3",
                     dout_valid, dout, rd_ptr, ram[2]);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_only_one: dout_valid=%b expected 0", dout_valid);
        end
        dout_ready = 1'b0;
        $display("[TB] test_clr done");
    endtask

    task automatic test_async_reset();
        int quiet_bad = 0;
        int gray_bad = 0;
        int k = 0;
        do_reset();
        dout_ready = 1'b1;
        wr_ptr = 5'd16;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        wr_ptr = '0;
        #1;
        tests_run++;
        if (rd_en_b !== 1'b0 || dout_valid !== 1'b0 || rd_ptr !== 5'd0 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL arst_values: rd_en_b=%b dout_valid=%b rd_ptr=%0d dout=%h expected 0 0 0 00",
                     rd_en_b, dout_valid, rd_ptr, dout);
        end
`ifdef VERSATILE_FIFO_RD_GRAY_EN
        tests_run++;
        if (rd_ptr_gray !== 5'd0) begin
            tests_failed++;
            $display("FAIL arst_gray: rd_ptr_gray=%0d expected 0", rd_ptr_gray);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rd_en_b !== 1'b0 || dout_valid !== 1'b0) quiet_bad++;
        end
        tests_run++;
        if (quiet_bad !== 0) begin
            tests_failed++;
            $display("FAIL arst_no_spurious: bad_cycles=%0d expected 0", quiet_bad);
        end
        wr_ptr = 5'd5;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef VERSATILE_FIFO_RD_GRAY_EN
            if (rd_ptr_gray !== (rd_ptr ^ (rd_ptr >> 1))) gray_bad++;
`endif
            if (dout_valid) begin
                tests_run++;
                if (k > 4 || dout !== ram[k % 16]) begin
                    tests_failed++;
                    $display("FAIL arst_data[%0d]: dout=%h expected %h", k, dout, ram[k % 16]);
                end
                k++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (k !== 5 || rd_ptr !== 5'd5 || gray_bad !== 0) begin
            tests_failed++;
            $display("FAIL arst_resume: words=%0d rd_ptr=%0d gray_bad=%0d expected 5 5 0",
                     k, rd_ptr, gray_bad);
        end
        dout_ready = 1'b0;
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 8'(8'hA5 + i * 19);
        end
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
